// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// A packet owner keeps the grant until its last byte's frame completes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_uart_transmit,
  output logic [7:0]             o_uart_tx_byte,
  input  logic                   i_uart_is_transmitting,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy,
  output logic [15:0]            o_bytes_sent
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOCKED, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last_owner;
  logic               r_last_q;
  logic [7:0]         r_tx_byte;
  logic               r_transmit;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_bytes_sent;

  logic [IDX_W:0]     w_cand;
  logic [IDX_W-1:0]   w_win;
  logic               w_found;
  logic [7:0]         w_sel_byte;
  logic               w_timeout;

  // Search starts one past the previous packet owner, wrapping at NUM_REQ.
  always_comb begin
    w_win   = r_last_owner;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last_owner} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ))
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      if (!w_found && i_req_valid[w_cand[IDX_W-1:0]]) begin
        w_win   = w_cand[IDX_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_sel_byte = i_req_data[{r_owner, 3'b000} +: 8];
  assign w_timeout  = (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_found) w_next = S_LOAD;
      S_LOCKED:    if (i_req_valid[r_owner]) w_next = S_LOAD;
      S_LOAD:      w_next = S_START;
      S_START:     if (!i_uart_is_transmitting) w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_uart_is_transmitting) w_next = S_WAIT_DONE;
        else if (w_timeout)         w_next = S_START;
      end
      S_WAIT_DONE: if (!i_uart_is_transmitting) w_next = r_last_q ? S_IDLE : S_LOCKED;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == S_LOAD) ? r_grant : '0;
    o_busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_last_q     <= 1'b0;
      r_tx_byte    <= 8'd0;
      r_transmit   <= 1'b0;
      r_cnt        <= '0;
      r_bytes_sent <= 16'd0;
    end else begin
      r_transmit <= 1'b0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_owner <= w_win;
          r_grant <= NUM_REQ'(1) << w_win;
        end
        S_LOAD: begin
          r_tx_byte <= w_sel_byte;
          r_last_q  <= i_req_last[r_owner];
        end
        S_START: if (!i_uart_is_transmitting) begin
          r_transmit <= 1'b1;
          r_cnt      <= '0;
        end
        S_WAIT_BUSY: if (!i_uart_is_transmitting) r_cnt <= r_cnt + 1'b1;
        S_WAIT_DONE: if (!i_uart_is_transmitting) begin
          r_bytes_sent <= r_bytes_sent + 16'd1;
          if (r_last_q) begin
            r_last_owner <= r_owner;
            r_grant      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_grant         = r_grant;
  assign o_uart_transmit = r_transmit;
  assign o_uart_tx_byte  = r_tx_byte;
  assign o_bytes_sent    = r_bytes_sent;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART and a transmit-order scoreboard.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 4;
  localparam int FRAME        = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   tb_valid = '0;
  logic [NUM_REQ-1:0]   tb_last  = '0;
  logic [8*NUM_REQ-1:0] tb_data  = '0;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_uart_transmit;
  logic [7:0]           o_uart_tx_byte;
  logic                 o_busy;
  logic [15:0]          o_bytes_sent;
  logic                 model_busy = 1'b0;
  logic                 force_busy = 1'b0;
  logic                 uart_in;
  int                   model_left = 0;
  int                   ignored = 0;
  int                   ignore_total = 0;

  typedef struct { int idx; logic [7:0] dat; } exp_t;
  exp_t       exp_q[$];
  logic [8:0] rq_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] acc;

  int   n_checks = 0;
  int   n_err = 0;
  int   acc_cnt [NUM_REQ];
  int   pulse_cnt = 0;
  int   cyc = 0;
  int   last_pulse_cyc = 0;
  int   prev_pulse_cyc = 0;
  logic prev_tx = 1'b0;

  assign uart_in = model_busy | force_busy;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(tb_valid), .i_req_data(tb_data), .i_req_last(tb_last),
    .o_req_ready(o_req_ready),
    .o_uart_transmit(o_uart_transmit), .o_uart_tx_byte(o_uart_tx_byte),
    .i_uart_is_transmitting(uart_in),
    .o_grant(o_grant), .o_busy(o_busy), .o_bytes_sent(o_bytes_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic last);
    rq_q[idx].push_back({last, d});
  endtask

  task automatic expect_tx(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx = idx;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_REQ; i++) rq_q[i].delete();
    exp_q.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    force_busy = 1'b0;
    ignore_total = 0;
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (o_bytes_sent != 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("bytes_sent_reached", 32'(o_bytes_sent), 32'(target));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UART: busy for FRAME cycles after an accepted pulse; can drop pulses on request.
  always @(posedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_left <= 0;
      ignored    <= 0;
    end else if (model_busy) begin
      if (model_left <= 1) model_busy <= 1'b0;
      model_left <= model_left - 1;
    end else if (o_uart_transmit && !force_busy) begin
      if (ignored < ignore_total) begin
        ignored <= ignored + 1;
      end else begin
        model_busy <= 1'b1;
        model_left <= FRAME;
      end
    end
  end

  // Requester driver: presents queue heads, pops on handshake.
  always begin
    @(posedge clk);
    acc = tb_valid & o_req_ready;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && rq_q[i].size() > 0) begin
        void'(rq_q[i].pop_front());
        acc_cnt[i]++;
      end
      if (rq_q[i].size() > 0) begin
        tb_valid[i]      = 1'b1;
        tb_data[8*i +: 8] = rq_q[i][0][7:0];
        tb_last[i]       = rq_q[i][0][8];
      end else begin
        tb_valid[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_uart_transmit) begin
        check("tx_single_cycle", 32'(prev_tx), 32'd0);
        pulse_cnt++;
        prev_pulse_cyc = last_pulse_cyc;
        last_pulse_cyc = cyc;
        if (!uart_in && ignored >= ignore_total) begin
          check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_tx_byte", 32'(o_uart_tx_byte), 32'(e.dat));
            check("sb_grant", 32'(o_grant), 32'(NUM_REQ'(1) << e.idx));
          end
        end
      end
      if (o_req_ready != '0) check("ready_eq_grant", 32'(o_req_ready), 32'(o_grant));
    end
    prev_tx = o_uart_transmit;
  end

  initial begin
    int a0, a1, p0, n;
    for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_transmit", 32'(o_uart_transmit), 32'd0);
    check("rst_tx_byte", 32'(o_uart_tx_byte), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_bytes", 32'(o_bytes_sent), 32'd0);

    // Single byte from requester 2
    send(2, 8'hA5, 1'b1);
    expect_tx(2, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    check("single_ready_c1", 32'(o_req_ready), 32'h4);
    @(negedge clk);
    check("single_busy_c2", 32'(o_busy), 32'd1);
    @(negedge clk);
    check("single_transmit_c3", 32'(o_uart_transmit), 32'd1);
    check("single_tx_byte", 32'(o_uart_tx_byte), 32'hA5);
    wait_bytes(1, 100);
    check("single_grant_end", 32'(o_grant), 32'd0);
    check("single_idle_end", 32'(o_busy), 32'd0);

    // Fairness: all four valid, requester 0 has a second packet queued
    reset_dut();
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    send(0, 8'h10, 1'b1); send(1, 8'h11, 1'b1); send(2, 8'h12, 1'b1);
    send(3, 8'h13, 1'b1); send(0, 8'h14, 1'b1);
    expect_tx(0, 8'h10); expect_tx(1, 8'h11); expect_tx(2, 8'h12);
    expect_tx(3, 8'h13); expect_tx(0, 8'h14);
    @(negedge clk);
    @(negedge clk);
    check("fair_first_grant", 32'(o_grant), 32'h1);
    wait_bytes(5, 400);
    check("fair_ready_cnt0", 32'(acc_cnt[0] - a0), 32'd2);
    check("fair_ready_cnt1", 32'(acc_cnt[1] - a1), 32'd1);

    // Packet lock: requester 1 holds 3 bytes while requester 0 waits
    reset_dut();
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    send(1, 8'h21, 1'b0); send(1, 8'h22, 1'b0); send(1, 8'h23, 1'b1);
    expect_tx(1, 8'h21); expect_tx(1, 8'h22); expect_tx(1, 8'h23); expect_tx(0, 8'h30);
    n = 0;
    while (o_grant !== 4'b0010 && n < 20) begin @(negedge clk); n++; end
    check("lock_grant1", 32'(o_grant), 32'h2);
    send(0, 8'h30, 1'b1);
    wait_bytes(3, 400);
    check("lock_no_ready0", 32'(acc_cnt[0] - a0), 32'd0);
    check("lock_ready1", 32'(acc_cnt[1] - a1), 32'd3);
    wait_bytes(4, 200);

    // UART busy held at START
    reset_dut();
    force_busy = 1'b1;
    p0 = pulse_cnt;
    send(1, 8'h3C, 1'b1);
    expect_tx(1, 8'h3C);
    repeat (8) @(negedge clk);
    check("busy_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("busy_stays_busy", 32'(o_busy), 32'd1);
    check("busy_no_ready", 32'(o_req_ready), 32'd0);
    force_busy = 1'b0;
    @(negedge clk);
    check("busy_release_pulse", 32'(o_uart_transmit), 32'd1);
    wait_bytes(1, 100);

    // Timeout: first pulse dropped by the UART
    reset_dut();
    ignore_total = 1;
    p0 = pulse_cnt;
    send(3, 8'h5A, 1'b1);
    expect_tx(3, 8'h5A);
    wait_bytes(1, 200);
    check("timeout_pulses", 32'(pulse_cnt - p0), 32'd2);
    check("timeout_gap", 32'(last_pulse_cyc - prev_pulse_cyc), 32'(BUSY_TIMEOUT + 1));

    // Reset during WAIT_DONE of a 2-byte packet
    reset_dut();
    send(0, 8'h40, 1'b1);
    expect_tx(0, 8'h40);
    wait_bytes(1, 100);
    send(2, 8'h41, 1'b0); send(2, 8'h42, 1'b1);
    expect_tx(2, 8'h41);
    n = 0;
    while (!(uart_in === 1'b1 && o_grant === 4'b0100) && n < 100) begin @(negedge clk); n++; end
    check("reach_wait_done", 32'(uart_in), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    flush();
    @(negedge clk);
    check("midrst_grant", 32'(o_grant), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_bytes", 32'(o_bytes_sent), 32'd0);
    check("midrst_transmit", 32'(o_uart_transmit), 32'd0);
    check("midrst_ready", 32'(o_req_ready), 32'd0);
    rst = 1'b0;
    send(3, 8'h50, 1'b1); send(0, 8'h51, 1'b1);
    expect_tx(0, 8'h51); expect_tx(3, 8'h50);
    @(negedge clk);
    @(negedge clk);
    check("midrst_rr_restart", 32'(o_grant), 32'h1);
    wait_bytes(2, 200);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart` transmitter among NUM_REQ byte requesters. Each requester offers bytes on a valid/ready handshake and can hold the grant across a multi-byte packet using `req_last`. The block drives the UART's `transmit`/`tx_byte` and tracks its `is_transmitting` flag so that frames never collide. It sits between on-chip agents (debug monitor, firmware console, status reporter) and the single UART TX pin.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- BUSY_TIMEOUT, 4: WAIT_BUSY cycles allowed before `transmit` is reissued, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high. Clock is `clk`.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i is the last of its packet.
- req_ready  out  NUM_REQ  one-hot; byte of the owner is accepted this cycle.
- uart_transmit  out  1  single-cycle start pulse to the UART; registered.
- uart_tx_byte  out  8  byte to the UART; registered; stable from LOAD until the next LOAD.
- uart_is_transmitting  in  1  UART busy flag.
- grant  out  NUM_REQ  one-hot current owner; 0 when no owner.
- busy  out  1  state != IDLE.
- bytes_sent  out  16  count of completed frames; wraps 0xFFFF→0.

## Operation
- Handshake: a transfer happens when `req_valid[i] & req_ready[i]`. While valid is high and ready is low, the requester holds data and last stable. `req_ready` is combinational: `(state==LOAD) ? grant : 0`.
- States:
  - IDLE: if any `req_valid`, pick a winner round-robin starting at `last_owner+1` mod NUM_REQ. Set `grant`=winner and go to LOAD.
  - LOCKED: the owner is mid-packet. Other requesters are ignored. Go to LOAD when `req_valid[owner]` is high.
  - LOAD: `req_ready[owner]`=1. Capture `uart_tx_byte` and `last_q`, then go to START.
  - START: if `uart_is_transmitting`=0, set the `uart_transmit` reg, clear the timeout counter, and go to WAIT_BUSY. Otherwise stay in START, which covers the UART finishing a previous frame.
  - WAIT_BUSY: `uart_transmit` clears after its single high cycle. On `uart_is_transmitting`=1 go to WAIT_DONE. Otherwise increment the counter; when it reaches BUSY_TIMEOUT, go back to START (reissue).
  - WAIT_DONE: on `uart_is_transmitting`=0, increment `bytes_sent`. If `last_q`, set `last_owner`=owner, clear `grant`, and go to IDLE. Otherwise go to LOCKED.
- `last_owner` is updated only on packet end, so a requester holding a packet blocks all others until its last byte completes.
- Dropping `req_valid[owner]` in LOCKED is legal. The block waits indefinitely and the grant is held.

## Timing
- Reset values: state IDLE, `grant`=0, `req_ready`=0, `uart_transmit`=0, `uart_tx_byte`=0, `busy`=0, `bytes_sent`=0, `last_owner`=NUM_REQ-1, so requester 0 wins first.
- Valid rises in IDLE at cycle 0. Then:
  - cycle 1: LOAD, ready high.
  - cycle 2: START.
  - cycle 3: `uart_transmit`=1.
  - cycle 4: UART busy seen, WAIT_DONE entered at cycle 5.
- Back-to-back packet bytes: LOCKED→LOAD takes 1 cycle after valid. Minimum spacing between bytes is one UART frame plus 4 cycles.
- `uart_transmit` is never high for two consecutive cycles. It is never asserted while `uart_is_transmitting`=1 was sampled in the same cycle.
- Reset mid-operation (the UART shares `rst`): all state returns to reset values within the same edge. A partial packet is abandoned, with no ready pulse and no count.
- Simultaneous valid from all requesters in IDLE: exactly one `grant` bit is set, chosen by the round-robin pointer.

## Test plan
- Single byte: `req_valid[2]`=1, data 0xA5, last=1 → `req_ready[2]` high in cycle 1, `uart_transmit` in cycle 3, `uart_tx_byte`=0xA5, `bytes_sent`=1, then IDLE with `grant`=0.
- Fairness: all four requesters present a 1-byte packet continuously → grant order 0,1,2,3,0; each gets exactly one ready pulse per round.
- Packet lock: requester 1 sends 3 bytes (last on the 3rd) while requester 0 is valid throughout → 1,1,1 transmitted before any `req_ready[0]`; `bytes_sent`=3.
- UART busy: hold `uart_is_transmitting`=1 at START → stay in START, no pulse; release → pulse on the next cycle.
- Timeout: the UART model ignores the first pulse → after 4 cycles in WAIT_BUSY, a second `uart_transmit` pulse follows; the frame then completes with `bytes_sent`+1.
- Reset in WAIT_DONE during a 2-byte packet → next cycle `grant`=0, `busy`=0, `bytes_sent`=0, `uart_transmit`=0; requester 0 wins the next arbitration.
